// File: rtl/fft_pkg.sv
// fft_pkg: shared helpers for the FFT front end (index width, bit-reversed slot mapping)
package fft_pkg;
  function automatic int idx_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic logic [31:0] bit_reverse(input logic [31:0] idx, input int nbits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < nbits; i++) r[nbits-1-i] = idx[i];
    return r;
  endfunction
endpackage

// File: rtl/fft_sample_deserializer_if.sv
// fft_sample_deserializer_if: recv (recv_msg/recv_val/recv_rdy) sample channel and send (send_msg_real/send_msg_imag/send_val/send_rdy) frame channel
interface fft_sample_deserializer_if #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
);
  logic [BIT_WIDTH-1:0] recv_msg;
  logic recv_val;
  logic recv_rdy;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_msg_real;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_msg_imag;
  logic send_val;
  logic send_rdy;
  modport master (
    output recv_msg, recv_val, send_rdy,
    input recv_rdy, send_msg_real, send_msg_imag, send_val
  );
  modport slave (
    input recv_msg, recv_val, send_rdy,
    output recv_rdy, send_msg_real, send_msg_imag, send_val
  );
endinterface

// File: rtl/fft_frame_bank.sv
// fft_frame_bank: N-entry register bank; clk, reset (async active-low), we/slot/wdata write port, rdata parallel read of all entries
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8,
  localparam int IW = idx_bits(N_SAMPLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic we,
  input  logic [IW-1:0] slot,
  input  logic [BIT_WIDTH-1:0] wdata,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] rdata
);
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] mem;
  always_ff @(posedge clk or negedge reset)
    if (!reset) mem <= '0;
    else if (we) mem[slot] <= wdata;
  assign rdata = mem;
endmodule

// File: rtl/fft_sample_deserializer.sv
// fft_sample_deserializer: ping-pong serial-to-parallel FFT front end; clk, reset (async active-low), io.slave = sample in (recv_*), complex frame out (send_*)
module fft_sample_deserializer
  import fft_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8,
  parameter int BIT_REVERSE = 0
) (
  input logic clk,
  input logic reset,
  fft_sample_deserializer_if.slave io
);
  localparam int IW = idx_bits(N_SAMPLES);
  logic [1:0] full;
  logic wr_bank, rd_bank;
  logic [IW-1:0] wr_idx, slot;
  logic recv_fire, send_fire, last;
  logic [1:0] set_m, clr_m;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] rdata [2];
  assign recv_fire = io.recv_val && io.recv_rdy;
  assign send_fire = io.send_val && io.send_rdy;
  assign last = wr_idx == IW'(N_SAMPLES - 1);
  assign slot = (BIT_REVERSE != 0) ? IW'(bit_reverse(32'(wr_idx), IW)) : wr_idx;
  // fill completion and send always target different banks, so both masks apply together
  assign set_m = {2{recv_fire && last}} & (wr_bank ? 2'b10 : 2'b01);
  assign clr_m = {2{send_fire}} & (rd_bank ? 2'b10 : 2'b01);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      full <= '0;
      wr_idx <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      full <= (full & ~clr_m) | set_m;
      if (recv_fire) wr_idx <= wr_idx + 1'b1;
      if (recv_fire && last) wr_bank <= ~wr_bank;
      if (send_fire) rd_bank <= ~rd_bank;
    end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank #(.BIT_WIDTH(BIT_WIDTH), .N_SAMPLES(N_SAMPLES)) u_bank (
      .clk(clk),
      .reset(reset),
      .we(recv_fire && wr_bank == 1'(b)),
      .slot(slot),
      .wdata(io.recv_msg),
      .rdata(rdata[b])
    );
  end
  assign io.recv_rdy = !full[wr_bank];
  assign io.send_val = full[rd_bank];
  assign io.send_msg_real = rdata[rd_bank];
  assign io.send_msg_imag = '0;
endmodule

// File: tb/tb_fft_sample_deserializer.sv
// tb_fft_sample_deserializer: table-driven plus scoreboard bench for natural and bit-reversed deserializers
module tb_fft_sample_deserializer;
  typedef logic [7:0][31:0] frame_t;
  typedef struct {
    frame_t samples;
    frame_t exp_nat;
    frame_t exp_rev;
  } vec_t;
  logic clk = 0;
  logic reset = 1;
  logic [31:0] recv_msg = '0;
  logic recv_val = 0;
  logic send_rdy = 0;
  logic mon_en = 0;
  int errors = 0;
  int checks = 0;
  int sends = 0;
  int cnt = 0;
  frame_t cur;
  frame_t q[$];
  vec_t tbl[3];
  fft_sample_deserializer_if #(.BIT_WIDTH(32), .N_SAMPLES(8)) if0 ();
  fft_sample_deserializer_if #(.BIT_WIDTH(32), .N_SAMPLES(8)) if1 ();
  assign if0.recv_msg = recv_msg;
  assign if0.recv_val = recv_val;
  assign if0.send_rdy = send_rdy;
  assign if1.recv_msg = recv_msg;
  assign if1.recv_val = recv_val;
  assign if1.send_rdy = send_rdy;
  fft_sample_deserializer #(.BIT_WIDTH(32), .N_SAMPLES(8), .BIT_REVERSE(0)) dut0 (
    .clk(clk), .reset(reset), .io(if0.slave));
  fft_sample_deserializer #(.BIT_WIDTH(32), .N_SAMPLES(8), .BIT_REVERSE(1)) dut1 (
    .clk(clk), .reset(reset), .io(if1.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic frame_t rev_frame(input frame_t f);
    frame_t r;
    for (int k = 0; k < 8; k++) begin
      logic [2:0] kk;
      kk = 3'(k);
      r[{kk[0], kk[1], kk[2]}] = f[k];
    end
    return r;
  endfunction
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      cnt = 0;
    end else begin
      if (if0.send_val && send_rdy) begin
        sends++;
        if (q.size() != 0) void'(q.pop_front());
      end
      if (recv_val && if0.recv_rdy) begin
        cur[cnt] = recv_msg;
        cnt++;
        if (cnt == 8) begin
          q.push_back(cur);
          cnt = 0;
        end
      end
    end
  end
  always @(negedge clk) if (mon_en) begin
    if (!reset) begin
      chk("rst_rdy", if0.recv_rdy, 1);
      chk("rst_val", if0.send_val, 0);
      chk("rst_msg", if0.send_msg_real, 0);
      chk("rst_msg_rev", if1.send_msg_real, 0);
    end else begin
      chk("mon_val", if0.send_val, q.size() != 0);
      chk("mon_rdy", if0.recv_rdy, q.size() < 2);
      chk("mon_val_rev", if1.send_val, q.size() != 0);
      chk("mon_rdy_rev", if1.recv_rdy, q.size() < 2);
      chk("mon_imag", if0.send_msg_imag, 0);
      chk("mon_imag_rev", if1.send_msg_imag, 0);
      if (q.size() != 0) begin
        chk("mon_real", if0.send_msg_real, q[0]);
        chk("mon_real_rev", if1.send_msg_real, rev_frame(q[0]));
      end
    end
  end
  task automatic put(input logic [31:0] v);
    int n;
    n = 0;
    recv_msg = v;
    recv_val = 1;
    while (!if0.recv_rdy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!if0.recv_rdy) chk("put_timeout", 0, 1);
    @(posedge clk); #1;
    recv_val = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    int rv[8];
    int s0;
    frame_t f;
    rv = '{0, 4, 2, 6, 1, 5, 3, 7};
    for (int k = 0; k < 8; k++) begin
      tbl[0].samples[k] = 32'(k + 1);
      tbl[1].samples[k] = 32'(k);
      tbl[2].samples[k] = 32'hA5A5_0000 + 32'(k) * 32'h1111;
    end
    for (int t = 0; t < 3; t++) begin
      tbl[t].exp_nat = tbl[t].samples;
      for (int k = 0; k < 8; k++) tbl[t].exp_rev[k] = tbl[t].samples[rv[k]];
    end
    #2 reset = 0;
    #1 mon_en = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy", if0.recv_rdy, 1);
    chk("reset_val", if0.send_val, 0);
    reset = 1;
    send_rdy = 1;
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 8; k++) begin
        if (k == 7) chk("tbl_early_val", if0.send_val, 0);
        put(tbl[t].samples[k]);
      end
      chk("tbl_val", if0.send_val, 1);
      chk("tbl_real", if0.send_msg_real, tbl[t].exp_nat);
      chk("tbl_rev", if1.send_msg_real, tbl[t].exp_rev);
      chk("tbl_imag", if0.send_msg_imag, 0);
      @(posedge clk); #1;
      chk("tbl_taken", if0.send_val, 0);
    end
    send_rdy = 0;
    s0 = sends;
    for (int i = 0; i < 16; i++) put(32'h10 + 32'(i));
    chk("stall_rdy", if0.recv_rdy, 0);
    for (int k = 0; k < 8; k++) f[k] = 32'h10 + 32'(k);
    recv_msg = 32'h20;
    recv_val = 1;
    for (int c = 0; c < 3; c++) begin
      chk("stall_hold", if0.send_msg_real, f);
      @(posedge clk); #1;
    end
    chk("stall_still", if0.recv_rdy, 0);
    send_rdy = 1;
    @(posedge clk); #1;
    chk("stall_exit", if0.recv_rdy, 1);
    for (int k = 0; k < 8; k++) f[k] = 32'h18 + 32'(k);
    chk("stall_f1", if0.send_msg_real, f);
    for (int i = 0; i < 8; i++) put(32'h20 + 32'(i));
    @(posedge clk); #1;
    chk("stall_drain", if0.send_val, 0);
    chk("stall_sends", sends - s0, 3);
    s0 = sends;
    for (int i = 0; i < 32; i++) begin
      chk("b2b_rdy", if0.recv_rdy, 1);
      put(32'h200 + 32'(i));
    end
    @(posedge clk); #1;
    chk("b2b_sends", sends - s0, 4);
    for (int i = 0; i < 5; i++) put(32'h50 + 32'(i));
    reset = 0;
    #1;
    chk("mid_rst_rdy", if0.recv_rdy, 1);
    chk("mid_rst_msg", if0.send_msg_real, 0);
    @(posedge clk); #1;
    reset = 1;
    for (int i = 0; i < 8; i++) begin
      chk("abort_val", if0.send_val, 0);
      put(32'd100 + 32'(i));
    end
    for (int k = 0; k < 8; k++) f[k] = 32'd100 + 32'(k);
    chk("abort_frame", if0.send_msg_real, f);
    @(posedge clk); #1;
    send_rdy = 0;
    for (int i = 0; i < 8; i++) put(32'h300 + 32'(i));
    for (int i = 0; i < 7; i++) put(32'h400 + 32'(i));
    chk("sim_pre_val", if0.send_val, 1);
    recv_msg = 32'h407;
    recv_val = 1;
    send_rdy = 1;
    @(posedge clk); #1;
    recv_val = 0;
    send_rdy = 0;
    for (int k = 0; k < 8; k++) f[k] = 32'h400 + 32'(k);
    chk("sim_val", if0.send_val, 1);
    chk("sim_rdy", if0.recv_rdy, 1);
    chk("sim_real", if0.send_msg_real, f);
    chk("sim_rev", if1.send_msg_real, rev_frame(f));
    send_rdy = 1;
    @(posedge clk); #1;
    chk("sim_drain", if0.send_val, 0);
    chk("final_empty", q.size(), 0);
    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fft_sample_deserializer.md
# fft_sample_deserializer

- Serial-to-parallel front end for the FFT stage pipeline.
- Accepts one real sample per val/rdy handshake and collects N_SAMPLES samples into a frame.
- Presents the frame as a parallel N-sample complex message (imaginary = 0) on the same val/rdy protocol the FFT stages consume.
- Double-buffered (ping-pong), so one frame can be filled while the previous one waits downstream.

## Interface
Parameters:
- BIT_WIDTH, 32, sample width (fixed-point, format untouched)
- N_SAMPLES, 8, samples per frame; power of two, ≥ 2
- BIT_REVERSE, 0, 1 = sample k stored at slot bitrev(k) over log2(N_SAMPLES) bits; 0 = slot k

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- recv_msg  in  BIT_WIDTH  incoming real sample
- recv_val  in  1  recv_msg valid
- recv_rdy  out  1  deserializer can accept a sample
- send_msg_real  out  BIT_WIDTH × [N_SAMPLES-1:0]  frame real parts
- send_msg_imag  out  BIT_WIDTH × [N_SAMPLES-1:0]  frame imaginary parts, constant 0
- send_val  out  1  complete frame available
- send_rdy  in  1  downstream FFT stage accepts frame

## Operation
- **Banks:** two N_SAMPLES × BIT_WIDTH banks (0, 1), each with a full flag.
- **Pointers:** wr_bank, rd_bank (1 bit each) and wr_idx (log2 N bits).
- **Receive handshake:** recv_val && recv_rdy writes recv_msg to bank[wr_bank][slot(wr_idx)], then increments wr_idx.
  - When wr_idx == N_SAMPLES-1: set full[wr_bank], wr_idx wraps to 0, wr_bank toggles.
- **recv_rdy** = !full[wr_bank]. It depends on registered state only; there is no combinational path from send_rdy or recv_val.
- **Outputs:** send_val = full[rd_bank]; send_msg_real[i] = bank[rd_bank][i]; send_msg_imag[i] = 0.
- **Send handshake:** send_val && send_rdy clears full[rd_bank] and toggles rd_bank. Bank contents are not cleared.
- **State (number of full banks):**
  - FILL (0 full): recv_rdy=1, send_val=0.
  - FILL_SEND (1 full): recv_rdy=1, send_val=1.
  - STALL (2 full): recv_rdy=0, send_val=1.
- **Transitions:**
  - FILL→FILL_SEND on the last sample.
  - FILL_SEND→STALL on last sample without a send handshake.
  - FILL_SEND→FILL on a send handshake without completing a fill.
  - FILL_SEND stays FILL_SEND when a fill completes and a send occurs in the same cycle.
  - STALL→FILL_SEND on a send handshake.
- **Simultaneous events:** fill completion and send in the same cycle act on different banks; both take effect.
- **Stall:** while send_val && !send_rdy, send_msg_real and send_msg_imag hold stable.
- **Reset (async, any time including mid-frame):**
  - full flags = 0, wr_idx = 0, wr_bank = rd_bank = 0, all bank entries = 0.
  - Any partial frame is discarded.
  - Outputs during reset: recv_rdy = 1, send_val = 0, send_msg_* = 0.

## Timing
- Latency: the last sample is accepted at edge t; send_val = 1 and the frame is valid after edge t (same cycle following t).
- Throughput: with send_rdy held 1, one sample is accepted every cycle indefinitely, with no bubbles at frame boundaries.
- STALL exit: a send handshake at edge t gives recv_rdy = 1 after edge t.
- A sample offered while recv_rdy = 0 is not consumed. The upstream holds it per val/rdy rules.

## Structure
- Shared package fft_pkg:
  - function bit_reverse(idx, nbits)
  - localparam helper for log2(N_SAMPLES)
- One sub-module fft_frame_bank, instantiated twice:
  - N-entry register bank with write enable, write slot, async active-low reset.
  - Parallel read of all entries.
- Top level holds the pointers, full flags and handshake logic.

## Test plan
All cases use N=8, BIT_WIDTH=32.
- **Basic frame:** reset release, then samples 1..8 on consecutive cycles with send_rdy=1 → send_val=1 one cycle after sample 8; send_msg_real = {1..8} at indices 0..7; imag all 0; handshake accepted.
- **Stall fill:** send_rdy=0, stream 24 samples (0x10..0x27) → recv_rdy drops after the 16th sample is accepted; frame 0 held stable. Raise send_rdy → frames {0x10..0x17} then {0x18..0x1F} delivered; recv_rdy=1 one cycle after the first send.
- **Back-to-back:** 32 continuous samples with send_rdy=1 → recv_rdy never 0; four frames, each send_val pulse aligned one cycle after its 8th sample.
- **Bit reversal:** BIT_REVERSE=1, samples 0..7 → send_msg_real = {0,4,2,6,1,5,3,7}.
- **Reset mid-frame:** 5 samples, assert reset for 1 cycle, then samples 100..107 → first frame is exactly {100..107}; send_val stays 0 throughout the aborted frame.
- **Simultaneous fill and send:** in FILL_SEND, 8th sample of the next frame arrives in the same cycle as send_rdy=1 → state stays FILL_SEND; new frame presented next cycle.
